// File: rtl/boot_stream_loader.sv
// Boot loader: takes a little-endian length header plus payload bytes and writes them as
// 32-bit words into SRAM while holding the CPU in reset. BOOT_LOADER_CHECKSUM_EN adds a trailing checksum byte.
module boot_stream_loader #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                SRAM_ADDR_W = 13,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              sram_valid,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic [3:0]        sram_wstrb,
  input  logic              sram_ready,
  output logic              boot,
  output logic              cpu_rst,
  output logic              busy,
  output logic              err
);

  localparam int          CNT_W   = SRAM_ADDR_W + 1;
  localparam logic [31:0] LEN_MAX = 32'd1 << SRAM_ADDR_W;

  typedef enum logic [2:0] {
    IDLE, HDR, DATA, WR, DONE, ERR
`ifdef BOOT_LOADER_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        hdr_cnt_reg, hdr_cnt_next;
  logic [31:0]       hdr_reg, hdr_next;
  logic [CNT_W-1:0]  byte_cnt_reg, byte_cnt_next;
  logic [1:0]        lane_reg, lane_next;
  logic [31:0]       stage_reg, stage_next;
  logic [ADDR_W-1:0] sram_addr_reg, addr_next;
  logic [DATA_W-1:0] sram_wdata_reg, wdata_next;
  logic [3:0]        sram_wstrb_reg, wstrb_next;
  logic              in_ready_reg, in_ready_next;
  logic              sram_valid_reg, sram_valid_next;
  logic              boot_reg, boot_next;
  logic              cpu_rst_reg, cpu_rst_next;
  logic              busy_reg, busy_next;
  logic              err_reg, err_next;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]        csum_reg, csum_next;
`endif

  logic              in_accept;
  logic [31:0]       hdr_shift;
  logic [CNT_W-1:0]  len_cur;
  logic [CNT_W-1:0]  byte_cnt_inc;
  logic [7:0]        lane_data [4];
  logic [3:0]        lane_fill;
  logic [31:0]       stage_upd;

  assign in_accept    = in_valid && in_ready_reg;
  assign hdr_shift    = {in_data, hdr_reg[31:8]};
  // After the header the shift register holds the byte count; it never exceeds LEN_MAX.
  assign len_cur      = hdr_reg[CNT_W-1:0];
  assign byte_cnt_inc = byte_cnt_reg + CNT_W'(1);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_data[gi] = (lane_reg == 2'(gi)) ? in_data : stage_reg[gi*8 +: 8];
      assign lane_fill[gi] = (2'(gi) <= lane_reg);
    end
  endgenerate

  assign stage_upd = {lane_data[3], lane_data[2], lane_data[1], lane_data[0]};

  always_comb begin
    state_next    = state_reg;
    hdr_cnt_next  = hdr_cnt_reg;
    hdr_next      = hdr_reg;
    byte_cnt_next = byte_cnt_reg;
    lane_next     = lane_reg;
    stage_next    = stage_reg;
    addr_next     = sram_addr_reg;
    wdata_next    = sram_wdata_reg;
    wstrb_next    = sram_wstrb_reg;
`ifdef BOOT_LOADER_CHECKSUM_EN
    csum_next     = csum_reg;
`endif
    case (state_reg)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_next    = HDR;
          hdr_cnt_next  = '0;
          hdr_next      = '0;
          byte_cnt_next = '0;
          lane_next     = '0;
          stage_next    = '0;
          addr_next     = BASE_ADDR;
          wdata_next    = '0;
          wstrb_next    = '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
          csum_next     = '0;
`endif
        end
      end
      HDR: begin
        if (in_accept) begin
          hdr_next     = hdr_shift;
          hdr_cnt_next = hdr_cnt_reg + 2'd1;
          if (hdr_cnt_reg == 2'd3) begin
            if (hdr_shift > LEN_MAX) begin
              state_next = ERR;
            end else if (hdr_shift == 32'd0) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
              state_next = CSUM;
`else
              state_next = DONE;
`endif
            end else begin
              state_next = DATA;
            end
          end
        end
      end
      DATA: begin
        if (in_accept) begin
          byte_cnt_next = byte_cnt_inc;
`ifdef BOOT_LOADER_CHECKSUM_EN
          csum_next     = csum_reg + in_data;
`endif
          // Lanes above the last staged byte are still zero, so a partial word is zero-filled.
          if (lane_reg == 2'd3 || byte_cnt_inc == len_cur) begin
            state_next = WR;
            wdata_next = stage_upd;
            wstrb_next = lane_fill;
            stage_next = '0;
            lane_next  = '0;
          end else begin
            stage_next = stage_upd;
            lane_next  = lane_reg + 2'd1;
          end
        end
      end
      WR: begin
        if (sram_ready) begin
          addr_next = sram_addr_reg + ADDR_W'(4);
          if (byte_cnt_reg != len_cur) begin
            state_next = DATA;
          end else begin
`ifdef BOOT_LOADER_CHECKSUM_EN
            state_next = CSUM;
`else
            state_next = DONE;
`endif
          end
        end
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      CSUM: begin
        if (in_accept) begin
          state_next = (in_data == csum_reg) ? DONE : ERR;
        end
      end
`endif
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they track the state register.
    in_ready_next   = 1'b0;
    sram_valid_next = 1'b0;
    boot_next       = 1'b1;
    cpu_rst_next    = 1'b1;
    busy_next       = 1'b0;
    err_next        = 1'b0;
    case (state_next)
      HDR, DATA: begin
        in_ready_next = 1'b1;
        busy_next     = 1'b1;
      end
      WR: begin
        sram_valid_next = 1'b1;
        busy_next       = 1'b1;
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      CSUM: begin
        in_ready_next = 1'b1;
        busy_next     = 1'b1;
      end
`endif
      DONE: begin
        boot_next    = 1'b0;
        cpu_rst_next = 1'b0;
      end
      ERR:     err_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      hdr_cnt_reg    <= '0;
      hdr_reg        <= '0;
      byte_cnt_reg   <= '0;
      lane_reg       <= '0;
      stage_reg      <= '0;
      sram_addr_reg  <= BASE_ADDR;
      sram_wdata_reg <= '0;
      sram_wstrb_reg <= '0;
      in_ready_reg   <= 1'b0;
      sram_valid_reg <= 1'b0;
      boot_reg       <= 1'b1;
      cpu_rst_reg    <= 1'b1;
      busy_reg       <= 1'b0;
      err_reg        <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      csum_reg       <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      hdr_cnt_reg    <= hdr_cnt_next;
      hdr_reg        <= hdr_next;
      byte_cnt_reg   <= byte_cnt_next;
      lane_reg       <= lane_next;
      stage_reg      <= stage_next;
      sram_addr_reg  <= addr_next;
      sram_wdata_reg <= wdata_next;
      sram_wstrb_reg <= wstrb_next;
      in_ready_reg   <= in_ready_next;
      sram_valid_reg <= sram_valid_next;
      boot_reg       <= boot_next;
      cpu_rst_reg    <= cpu_rst_next;
      busy_reg       <= busy_next;
      err_reg        <= err_next;
`ifdef BOOT_LOADER_CHECKSUM_EN
      csum_reg       <= csum_next;
`endif
    end
  end

  assign in_ready   = in_ready_reg;
  assign sram_valid = sram_valid_reg;
  assign sram_addr  = sram_addr_reg;
  assign sram_wdata = sram_wdata_reg;
  assign sram_wstrb = sram_wstrb_reg;
  assign boot       = boot_reg;
  assign cpu_rst    = cpu_rst_reg;
  assign busy       = busy_reg;
  assign err        = err_reg;

endmodule
